// File: rtl/m65c02_alu_pkg.sv
// Shared types and constants for the M65C02 ALU arbiter.
package m65c02_alu_pkg;

  // Control word field layout, MSB first: Reg_WE, FU_Sel, Op, QSel, RSel, CSel, WSel, OSel, CCSel
  localparam int unsigned CwRegWeLsb = 23;
  localparam int unsigned CwRegWeW   = 3;
  localparam int unsigned CwFuSelLsb = 18;
  localparam int unsigned CwFuSelW   = 5;
  localparam int unsigned CwOpLsb    = 16;
  localparam int unsigned CwOpW      = 2;
  localparam int unsigned CwQSelLsb  = 14;
  localparam int unsigned CwQSelW    = 2;
  localparam int unsigned CwRSelLsb  = 12;
  localparam int unsigned CwRSelW    = 2;
  localparam int unsigned CwCSelLsb  = 10;
  localparam int unsigned CwCSelW    = 2;
  localparam int unsigned CwWSelLsb  = 7;
  localparam int unsigned CwWSelW    = 3;
  localparam int unsigned CwOSelLsb  = 4;
  localparam int unsigned CwOSelW    = 3;
  localparam int unsigned CwCcSelLsb = 0;
  localparam int unsigned CwCcSelW   = 4;

  // Counter widths: starvation limit up to 15, ALU latency up to 4
  localparam int unsigned StarveCntW = 4;
  localparam int unsigned WaitCntW   = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10
  } state_e;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

endpackage

// File: rtl/m65c02_arb_prio.sv
// Priority pick between A and B with a saturating starvation counter guaranteeing B progress.
module m65c02_arb_prio
  import m65c02_alu_pkg::*;
#(
  parameter int unsigned STARVE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE);

  logic [StarveCntW-1:0] cnt_q, cnt_d;
  logic                  starved;

  // Grant pick: A wins ties unless B has waited through STARVE A grants
  always_comb begin
    starved = (cnt_q == StarveMax);
    gnt_b_o = en_i & b_req_i & (~a_req_i | starved);
    gnt_a_o = en_i & a_req_i & ~gnt_b_o;
  end

  // Starvation count: counts A grants that bypass a waiting B, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_b_o) begin
      cnt_d = '0;
    end else if (gnt_a_o) begin
      if (!b_req_i) begin
        cnt_d = '0;
      end else if (!starved) begin
        cnt_d = cnt_q + StarveCntW'(1);
      end
    end
  end

  // Starvation count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/m65c02_alu_arb.sv
// Two-requester arbiter and issue sequencer for the shared M65C02 ALU.
module m65c02_alu_arb
  import m65c02_alu_pkg::*;
#(
  parameter int unsigned CW_W   = 26,
  parameter int unsigned LAT    = 1,
  parameter int unsigned STARVE = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rdy_i,
  input  logic            a_req_i,
  input  logic [CW_W-1:0] a_cw_i,
  input  logic [7:0]      a_m_i,
  output logic            a_ack_o,
  output logic            a_done_o,
  input  logic            b_req_i,
  input  logic [CW_W-1:0] b_cw_i,
  input  logic [7:0]      b_m_i,
  output logic            b_ack_o,
  output logic            b_done_o,
  output logic [7:0]      rsp_do_o,
  output logic            rsp_cc_o,
  output logic            alu_en_o,
  output logic [CW_W-1:0] alu_cw_o,
  output logic [7:0]      alu_m_o,
  input  logic            alu_val_i,
  input  logic [7:0]      alu_do_i,
  input  logic            alu_cc_i,
  output logic            busy_o
);

  localparam logic [WaitCntW-1:0] WaitInit = WaitCntW'(LAT - 1);

  state_e                state_q, state_d;
  owner_e                owner_q;
  logic [WaitCntW-1:0]   wcnt_q;
  logic [CW_W-1:0]       cw_q;
  logic [7:0]            m_q;
  logic [7:0]            rsp_do_q;
  logic                  rsp_cc_q;
  logic                  done_a_q, done_b_q;
  // Sticky: a WAIT expired without ALU_Val (protocol error, observed in simulation)
  logic                  prot_err_q;

  logic                  arb_en, gnt_a, gnt_b, gnt_any, complete, timeout;

  // Grants only in IDLE on a Rdy cycle; held off while reset is asserted so outputs stay 0
  assign arb_en = rdy_i & rst_ni & (state_q == StIdle);

  m65c02_arb_prio #(
    .STARVE (STARVE)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (arb_en),
    .a_req_i (a_req_i),
    .b_req_i (b_req_i),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  // Completion: ALU result, or wait counter running out at zero without one
  always_comb begin
    gnt_any  = gnt_a | gnt_b;
    complete = rdy_i & (state_q == StWait) & (alu_val_i | (wcnt_q == '0));
    timeout  = complete & ~alu_val_i;
  end

  // FSM state register, frozen while Rdy is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else if (rdy_i) begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_any) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (alu_val_i || (wcnt_q == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: strobes suppressed while Rdy is low
  always_comb begin
    a_ack_o  = gnt_a;
    b_ack_o  = gnt_b;
    alu_en_o = rdy_i & (state_q == StIssue);
    a_done_o = rdy_i & done_a_q;
    b_done_o = rdy_i & done_b_q;
    busy_o   = (state_q != StIdle);
    alu_cw_o = cw_q;
    alu_m_o  = m_q;
    rsp_do_o = rsp_do_q;
    rsp_cc_o = rsp_cc_q;
  end

  // Datapath: operand capture on grant, wait counter, response and Done pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= OwnA;
      wcnt_q     <= '0;
      cw_q       <= '0;
      m_q        <= '0;
      rsp_do_q   <= '0;
      rsp_cc_q   <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      prot_err_q <= 1'b0;
    end else if (rdy_i) begin
      if (gnt_any) begin
        cw_q    <= gnt_b ? b_cw_i : a_cw_i;
        m_q     <= gnt_b ? b_m_i : a_m_i;
        owner_q <= gnt_b ? OwnB : OwnA;
      end
      if (state_q == StIssue) begin
        wcnt_q <= WaitInit;
      end else if ((state_q == StWait) && (wcnt_q != '0)) begin
        wcnt_q <= wcnt_q - WaitCntW'(1);
      end
      done_a_q <= complete & (owner_q == OwnA);
      done_b_q <= complete & (owner_q == OwnB);
      if (complete) begin
        rsp_do_q <= alu_do_i;
        rsp_cc_q <= alu_val_i & alu_cc_i;
      end
      if (timeout) begin
        prot_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m65c02_alu_arb.sv
// Directed bench for m65c02_alu_arb: one LAT=1 instance with an ALU model, one LAT=3 with no Val.
module tb_m65c02_alu_arb;

  logic clk = 1'b0;
  logic rst_n, rdy;
  always #5 clk = ~clk;

  // LAT=1 instance signals
  logic        a_req, b_req, a_ack, b_ack, a_done, b_done;
  logic [25:0] a_cw, b_cw, alu_cw;
  logic [7:0]  a_m, b_m, alu_m, rsp_do, alu_do;
  logic        rsp_cc, alu_en, alu_val, alu_cc, busy;

  // LAT=3 instance signals
  logic        c_req, c_ack, c_done, c_en, c_busy, c_rsp_cc, c_val, c_alu_cc;
  logic [25:0] c_cw, c_alu_cw, c_bcw;
  logic [7:0]  c_m, c_alu_m, c_rsp_do, c_alu_do, c_bm;
  logic        c_breq, c_back, c_bdone;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_b = 10'b10_0001_0000;

  m65c02_alu_arb #(.CW_W(26), .LAT(1), .STARVE(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy),
    .a_req_i(a_req), .a_cw_i(a_cw), .a_m_i(a_m), .a_ack_o(a_ack), .a_done_o(a_done),
    .b_req_i(b_req), .b_cw_i(b_cw), .b_m_i(b_m), .b_ack_o(b_ack), .b_done_o(b_done),
    .rsp_do_o(rsp_do), .rsp_cc_o(rsp_cc), .alu_en_o(alu_en), .alu_cw_o(alu_cw),
    .alu_m_o(alu_m), .alu_val_i(alu_val), .alu_do_i(alu_do), .alu_cc_i(alu_cc), .busy_o(busy)
  );

  m65c02_alu_arb #(.CW_W(26), .LAT(3), .STARVE(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy),
    .a_req_i(c_req), .a_cw_i(c_cw), .a_m_i(c_m), .a_ack_o(c_ack), .a_done_o(c_done),
    .b_req_i(c_breq), .b_cw_i(c_bcw), .b_m_i(c_bm), .b_ack_o(c_back), .b_done_o(c_bdone),
    .rsp_do_o(c_rsp_do), .rsp_cc_o(c_rsp_cc), .alu_en_o(c_en), .alu_cw_o(c_alu_cw),
    .alu_m_o(c_alu_m), .alu_val_i(c_val), .alu_do_i(c_alu_do), .alu_cc_i(c_alu_cc),
    .busy_o(c_busy)
  );

  // One-cycle-latency ALU model; holds its result while Rdy is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_val <= 1'b0;
    else if (rdy) alu_val <= alu_en;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1;
    a_req = 1'b0; a_cw = '0; a_m = '0; b_req = 1'b0; b_cw = '0; b_m = '0;
    alu_do = '0; alu_cc = 1'b0;
    c_req = 1'b0; c_cw = '0; c_m = '0; c_val = 1'b0; c_alu_do = 8'h9D; c_alu_cc = 1'b1;
    c_breq = 1'b0; c_bcw = '0; c_bm = '0;

    // Reset state
    smp();
    chk1("rst_a_ack", a_ack, 1'b0);   chk1("rst_b_ack", b_ack, 1'b0);
    chk1("rst_a_done", a_done, 1'b0); chk1("rst_b_done", b_done, 1'b0);
    chk1("rst_en", alu_en, 1'b0);     chk1("rst_busy", busy, 1'b0);
    chkw("rst_cw", 32'(alu_cw), 32'h0); chkw("rst_m", 32'(alu_m), 32'h0);
    chkw("rst_do", 32'(rsp_do), 32'h0); chk1("rst_cc", rsp_cc, 1'b0);
    nxt(); rst_n = 1'b1;
    smp(); chk1("idle_busy", busy, 1'b0);

    // Single A op, LAT=1
    nxt(); a_req = 1'b1; a_cw = 26'h0ABCDEF; a_m = 8'h5A; alu_do = 8'hC3; alu_cc = 1'b1;
    smp(); chk1("t0_a_ack", a_ack, 1'b1); chk1("t0_b_ack", b_ack, 1'b0);
    nxt(); a_req = 1'b0;
    smp(); chk1("t1_en", alu_en, 1'b1); chkw("t1_cw", 32'(alu_cw), 32'h0ABCDEF);
    chkw("t1_m", 32'(alu_m), 32'h5A); chk1("t1_ack", a_ack, 1'b0); chk1("t1_busy", busy, 1'b1);
    nxt(); smp(); chk1("t2_en", alu_en, 1'b0); chk1("t2_done", a_done, 1'b0);
    nxt(); smp(); chk1("t3_done", a_done, 1'b1); chkw("t3_do", 32'(rsp_do), 32'hC3);
    chk1("t3_cc", rsp_cc, 1'b1); chk1("t3_busy", busy, 1'b0);
    nxt(); smp(); chk1("t4_done", a_done, 1'b0);

    // Back-to-back A ops: Done and next Ack coincide, one op per 3 cycles
    nxt(); a_req = 1'b1; a_cw = 26'h1111111; a_m = 8'h01; alu_do = 8'h21; alu_cc = 1'b0;
    smp(); chk1("bb0_ack", a_ack, 1'b1);
    nxt(); a_cw = 26'h2222222; a_m = 8'h02;
    smp(); chk1("bb1_en", alu_en, 1'b1); chkw("bb1_cw", 32'(alu_cw), 32'h1111111);
    chk1("bb1_ack", a_ack, 1'b0);
    nxt(); smp(); chkw("bb2_do_hold", 32'(rsp_do), 32'hC3);
    nxt(); alu_do = 8'h42;
    smp(); chk1("bb3_done", a_done, 1'b1); chk1("bb3_ack", a_ack, 1'b1);
    chkw("bb3_do", 32'(rsp_do), 32'h21); chk1("bb3_cc", rsp_cc, 1'b0);
    nxt(); a_req = 1'b0;
    smp(); chk1("bb4_en", alu_en, 1'b1); chkw("bb4_cw", 32'(alu_cw), 32'h2222222);
    chkw("bb4_m", 32'(alu_m), 32'h02); chk1("bb4_done", a_done, 1'b0);
    chkw("bb4_do_hold", 32'(rsp_do), 32'h21);
    nxt(); nxt();
    smp(); chk1("bb6_done", a_done, 1'b1); chkw("bb6_do", 32'(rsp_do), 32'h42);
    chk1("bb6_ack", a_ack, 1'b0);

    // Contention with STARVE=4: A,A,A,A,B,A,A,A,A,B
    nxt(); a_req = 1'b1; b_req = 1'b1; a_cw = 26'h0000AAA; b_cw = 26'h3333333;
    alu_do = 8'h77; alu_cc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk1($sformatf("cont%0d_a_ack", k), a_ack, ~exp_b[k]);
      chk1($sformatf("cont%0d_b_ack", k), b_ack, exp_b[k]);
      if (k > 0) begin
        chk1($sformatf("cont%0d_a_done", k), a_done, ~exp_b[k-1]);
        chk1($sformatf("cont%0d_b_done", k), b_done, exp_b[k-1]);
      end
      nxt();
      if (k == 9) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      nxt(); nxt();
    end
    smp(); chk1("cont_end_b_done", b_done, 1'b1); chk1("cont_end_a_ack", a_ack, 1'b0);
    chkw("cont_end_do", 32'(rsp_do), 32'h77);

    // Rdy stall for 3 cycles in WAIT delays Done by exactly 3
    nxt(); a_req = 1'b1; a_cw = 26'h0C0FFEE; alu_do = 8'h3C; alu_cc = 1'b1;
    smp(); chk1("st0_ack", a_ack, 1'b1);
    nxt(); a_req = 1'b0;
    smp(); chk1("st1_en", alu_en, 1'b1);
    nxt(); rdy = 1'b0;
    smp(); chk1("st2_en", alu_en, 1'b0); chk1("st2_done", a_done, 1'b0);
    chkw("st2_do_hold", 32'(rsp_do), 32'h77); chk1("st2_busy", busy, 1'b1);
    nxt(); smp(); chk1("st3_done", a_done, 1'b0);
    nxt(); smp(); chk1("st4_done", a_done, 1'b0); chkw("st4_do_hold", 32'(rsp_do), 32'h77);
    nxt(); rdy = 1'b1;
    smp(); chk1("st5_done", a_done, 1'b0); chk1("st5_busy", busy, 1'b1);
    nxt(); smp(); chk1("st6_done", a_done, 1'b1); chkw("st6_do", 32'(rsp_do), 32'h3C);
    chk1("st6_cc", rsp_cc, 1'b1);
    // Ack suppressed while Rdy is low in IDLE, then granted on the first Rdy cycle
    nxt(); rdy = 1'b0; b_req = 1'b1; b_cw = 26'h0000055; b_m = 8'hB5;
    smp(); chk1("st7_b_ack", b_ack, 1'b0); chk1("st7_busy", busy, 1'b0);
    nxt(); rdy = 1'b1;
    smp(); chk1("st8_b_ack", b_ack, 1'b1);
    nxt(); b_req = 1'b0;
    smp(); chk1("st9_en", alu_en, 1'b1); chkw("st9_cw", 32'(alu_cw), 32'h0000055);

    // Async reset mid-WAIT: outputs clear at once, no Done, B-only granted on first IDLE
    nxt(); rst_n = 1'b0; b_req = 1'b1; b_cw = 26'h0000066;
    smp(); chk1("ar_a_ack", a_ack, 1'b0); chk1("ar_b_ack", b_ack, 1'b0);
    chk1("ar_b_done", b_done, 1'b0); chk1("ar_en", alu_en, 1'b0); chk1("ar_busy", busy, 1'b0);
    chkw("ar_cw", 32'(alu_cw), 32'h0); chkw("ar_m", 32'(alu_m), 32'h0);
    chkw("ar_do", 32'(rsp_do), 32'h0); chk1("ar_cc", rsp_cc, 1'b0);
    nxt(); rst_n = 1'b1;
    smp(); chk1("ar1_b_ack", b_ack, 1'b1); chk1("ar1_b_done", b_done, 1'b0);
    nxt(); b_req = 1'b0; alu_do = 8'hE7; alu_cc = 1'b0;
    smp(); chk1("ar2_en", alu_en, 1'b1); chkw("ar2_cw", 32'(alu_cw), 32'h0000066);
    chk1("ar2_b_done", b_done, 1'b0);
    nxt(); smp(); chk1("ar3_b_done", b_done, 1'b0);
    nxt(); smp(); chk1("ar4_b_done", b_done, 1'b1); chkw("ar4_do", 32'(rsp_do), 32'hE7);

    // LAT=3 with no ALU_Val: completes on counter underflow, CC forced 0, error flagged
    nxt(); c_req = 1'b1; c_cw = 26'h1234567; c_m = 8'hAA;
    smp(); chk1("l3_ack", c_ack, 1'b1); chk1("l3_err0", dut3.prot_err_q, 1'b0);
    nxt(); c_req = 1'b0;
    smp(); chk1("l3_en", c_en, 1'b1); chkw("l3_cw", 32'(c_alu_cw), 32'h1234567);
    nxt(); smp(); chk1("l3_w1_done", c_done, 1'b0);
    nxt(); smp(); chk1("l3_w2_done", c_done, 1'b0);
    nxt(); smp(); chk1("l3_w3_done", c_done, 1'b0); chk1("l3_w3_busy", c_busy, 1'b1);
    nxt(); smp(); chk1("l3_done", c_done, 1'b1); chkw("l3_do", 32'(c_rsp_do), 32'h9D);
    chk1("l3_cc", c_rsp_cc, 1'b0); chk1("l3_err1", dut3.prot_err_q, 1'b1);
    chk1("l3_busy", c_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
